// File: rtl/prog_loader.sv
// Program loader: assembles a checksummed byte stream into 16-bit instruction
// words, writes them to program memory from address 0 and releases the CPU reset.
module prog_loader #(
    parameter int unsigned DATA_WIDTH        = 11,
    parameter int unsigned INSTRUCTION_WIDTH = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    input  logic                         reload,
    output logic                         pm_wr,
    output logic [DATA_WIDTH-1:0]        pm_addr,
    output logic [INSTRUCTION_WIDTH:0]   pm_data,
    output logic                         cpu_reset,
    output logic                         done,
    output logic                         error,
    output logic [DATA_WIDTH:0]          loaded_count
);

    localparam int unsigned WORD_W  = INSTRUCTION_WIDTH + 1;
    localparam int unsigned CNT_W   = DATA_WIDTH + 1;
    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(1 << DATA_WIDTH);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        INS_HI = 3'd2,
        INS_LO = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           hi_q, hi_d;
    logic [7:0]           acc_q, acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   count_in;
    logic [CNT_W-1:0]     lc_inc;
    logic                 xfer;
    logic                 restart;

    logic                 rx_ready_d, pm_wr_d, cpu_reset_d, done_d, error_d;
    logic [DATA_WIDTH-1:0] pm_addr_d;
    logic [WORD_W-1:0]    pm_data_d;
    logic [CNT_W-1:0]     loaded_count_d;

    assign xfer     = rx_valid & rx_ready;
    assign count_in = {hi_q, rx_data};
    assign lc_inc   = loaded_count + CNT_W'(1);
    assign restart  = reload & ((state_q == DONE) | (state_q == ERROR));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the state only advances on an accepted byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_HI: if (xfer) state_d = CNT_LO;
            CNT_LO: begin
                if (xfer) begin
                    if (count_in > MAX_COUNT)       state_d = ERROR;
                    else if (count_in == '0)        state_d = CHECK;
                    else                            state_d = INS_HI;
                end
            end
            INS_HI: if (xfer) state_d = INS_LO;
            INS_LO: if (xfer) state_d = WRITE;
            WRITE:  state_d = (COUNT_W'(lc_inc) == count_q) ? CHECK : INS_HI;
            CHECK: begin
                if (xfer) state_d = (rx_data == acc_q) ? DONE : ERROR;
            end
            DONE:   if (reload) state_d = CNT_HI;
            ERROR:  if (reload) state_d = CNT_HI;
            default: state_d = CNT_HI;
        endcase
    end

    // Output/datapath next values; status outputs are registered from state_d
    always_comb begin
        rx_ready_d     = (state_d == CNT_HI) | (state_d == CNT_LO) |
                         (state_d == INS_HI) | (state_d == INS_LO) |
                         (state_d == CHECK);
        pm_wr_d        = (state_d == WRITE);
        done_d         = (state_d == DONE);
        error_d        = (state_d == ERROR);
        cpu_reset_d    = (state_d == DONE);
        pm_addr_d      = pm_addr;
        pm_data_d      = pm_data;
        loaded_count_d = loaded_count;
        hi_d           = hi_q;
        acc_d          = acc_q;
        count_d        = count_q;

        if (xfer && (state_q != CHECK)) begin
            acc_d = acc_q ^ rx_data;
        end
        if (xfer && ((state_q == CNT_HI) || (state_q == INS_HI))) begin
            hi_d = rx_data;
        end
        if (xfer && (state_q == CNT_LO)) begin
            count_d = count_in;
        end
        // Word is staged on the low byte so it is on the bus during WRITE
        if (xfer && (state_q == INS_LO)) begin
            pm_addr_d = loaded_count[DATA_WIDTH-1:0];
            pm_data_d = WORD_W'({hi_q, rx_data});
        end
        if (state_q == WRITE) begin
            loaded_count_d = lc_inc;
        end
        if (restart) begin
            loaded_count_d = '0;
            acc_d          = '0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ready     <= 1'b0;
            pm_wr        <= 1'b0;
            pm_addr      <= '0;
            pm_data      <= '0;
            cpu_reset    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded_count <= '0;
            hi_q         <= '0;
            acc_q        <= '0;
            count_q      <= '0;
        end else begin
            rx_ready     <= rx_ready_d;
            pm_wr        <= pm_wr_d;
            pm_addr      <= pm_addr_d;
            pm_data      <= pm_data_d;
            cpu_reset    <= cpu_reset_d;
            done         <= done_d;
            error        <= error_d;
            loaded_count <= loaded_count_d;
            hi_q         <= hi_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and randomized images checked against a
// stream-level model of the expected writes and final status.
module tb_prog_loader;

    localparam int unsigned DW = 11;
    localparam int unsigned IW = 15;
    localparam int MAXC = 1 << DW;

    logic          clock;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          pm_wr;
    logic [DW-1:0] pm_addr;
    logic [IW:0]   pm_data;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [DW:0]   loaded_count;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] wr_addr_q[$];
    logic [IW:0]   wr_data_q[$];

    logic [IW:0]   exp_words[$];
    logic          exp_done;
    logic          exp_err;
    int            exp_n;

    prog_loader #(.DATA_WIDTH(DW), .INSTRUCTION_WIDTH(IW)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .reload(reload), .pm_wr(pm_wr), .pm_addr(pm_addr),
        .pm_data(pm_data), .cpu_reset(cpu_reset), .done(done), .error(error),
        .loaded_count(loaded_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every program-memory write strobe
    always @(negedge clock) begin
        if (pm_wr) begin
            wr_addr_q.push_back(pm_addr);
            wr_data_q.push_back(pm_data);
        end
    end

    // Stream-level reference: parse count, words and checksum from the byte list
    task automatic model(input logic [7:0] s[$]);
        int c;
        logic [7:0] x;
        exp_words.delete();
        c = int'({s[0], s[1]});
        if (c > MAXC) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_n = 0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 2 * c; i++) x = x ^ s[i];
        for (int k = 0; k < c; k++) exp_words.push_back({s[2 + 2 * k], s[3 + 2 * k]});
        exp_n    = c;
        exp_done = (s[2 + 2 * c] == x);
        exp_err  = !exp_done;
    endtask

    // mode 0: valid held high, 1: toggling, 2: random
    task automatic send(input logic [7:0] s[$], input int mode);
        int  idx = 0;
        int  cyc = 0;
        bit  ph  = 1'b1;
        bit  take;
        wr_addr_q.delete();
        wr_data_q.delete();
        while (idx < s.size() && cyc < 20 * s.size() + 50) begin
            @(negedge clock);
            cyc++;
            rx_data  = s[idx];
            if (mode == 0)      rx_valid = 1'b1;
            else if (mode == 1) rx_valid = ph | pm_wr;
            else                rx_valid = 1'($urandom_range(0, 1)) | pm_wr;
            ph   = !ph;
            take = rx_valid && rx_ready;
            @(posedge clock);
            if (take) idx++;
        end
        @(negedge clock);
        rx_valid = 1'b0;
        if (idx < s.size()) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, s.size());
        end
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
        repeat (2) @(negedge clock);
        n_vec++;
        if ({rx_ready, pm_wr, pm_addr, pm_data, cpu_reset, done, error, loaded_count} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b wr=%b addr=%h data=%h cpu=%b done=%b err=%b lc=%0d, want all 0",
                     rx_ready, pm_wr, pm_addr, pm_data, cpu_reset, done, error, loaded_count);
        end
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({rx_ready, done, error, cpu_reset} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release: got rdy/done/err/cpu=%b, want 1000", {rx_ready, done, error, cpu_reset});
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[$] = '{8'h00, 8'h02, 8'h18, 8'h05, 8'h00, 8'h00, 8'h1F};
        model(s);
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 2 || wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== 16'h1805 ||
            wr_addr_q[1] !== 11'd1 || wr_data_q[1] !== 16'h0000) begin
            n_err++;
            $display("FAIL basic_writes: got %0d writes, want (0,1805),(1,0000)", wr_data_q.size());
        end
        n_vec++;
        if ({done, error, cpu_reset, rx_ready} !== 4'b1010 || loaded_count !== 12'd2) begin
            n_err++;
            $display("FAIL basic_status: got done/err/cpu/rdy=%b lc=%0d, want 1010 lc=2",
                     {done, error, cpu_reset, rx_ready}, loaded_count);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$] = '{8'h00, 8'h02, 8'h18, 8'h05, 8'h00, 8'h00, 8'h1E};
        pulse_reload();
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 2 || wr_data_q[0] !== 16'h1805 || wr_addr_q[1] !== 11'd1) begin
            n_err++;
            $display("FAIL badsum_writes: got %0d writes, want 2", wr_data_q.size());
        end
        n_vec++;
        if ({done, error, cpu_reset, rx_ready} !== 4'b0100) begin
            n_err++;
            $display("FAIL badsum_status: got done/err/cpu/rdy=%b, want 0100", {done, error, cpu_reset, rx_ready});
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] s[$] = '{8'h00, 8'h00, 8'h00};
        pulse_reload();
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 0 || {done, error, cpu_reset} !== 3'b101 || loaded_count !== 12'd0) begin
            n_err++;
            $display("FAIL zero_count: got writes=%0d done/err/cpu=%b lc=%0d, want 0 101 0",
                     wr_data_q.size(), {done, error, cpu_reset}, loaded_count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s[$] = '{8'h08, 8'h01};
        pulse_reload();
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 0 || {done, error, cpu_reset, rx_ready} !== 4'b0100) begin
            n_err++;
            $display("FAIL overflow: got writes=%0d done/err/cpu/rdy=%b, want 0 0100",
                     wr_data_q.size(), {done, error, cpu_reset, rx_ready});
        end
    endtask

    task automatic test_toggle();
        logic [7:0] s[$] = '{8'h00, 8'h02, 8'h18, 8'h05, 8'h00, 8'h00, 8'h1F};
        pulse_reload();
        model(s);
        send(s, 1);
        n_vec++;
        if (wr_data_q.size() !== exp_words.size() || wr_data_q[0] !== exp_words[0] ||
            wr_data_q[1] !== exp_words[1] || wr_addr_q[1] !== 11'd1) begin
            n_err++;
            $display("FAIL toggle_writes: got %0d writes, want %0d", wr_data_q.size(), exp_words.size());
        end
        n_vec++;
        if ({done, error, cpu_reset} !== {exp_done, exp_err, exp_done} || loaded_count !== 12'(exp_n)) begin
            n_err++;
            $display("FAIL toggle_status: got done/err/cpu=%b lc=%0d, want %b%b%b lc=%0d",
                     {done, error, cpu_reset}, loaded_count, exp_done, exp_err, exp_done, exp_n);
        end
    endtask

    task automatic test_reload();
        logic [7:0] s[$] = '{8'h00, 8'h01, 8'h70, 8'h03, 8'h72};
        pulse_reload();
        n_vec++;
        if ({cpu_reset, done, error, rx_ready} !== 4'b0001 || loaded_count !== 12'd0) begin
            n_err++;
            $display("FAIL reload_clear: got cpu/done/err/rdy=%b lc=%0d, want 0001 lc=0",
                     {cpu_reset, done, error, rx_ready}, loaded_count);
        end
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 1 || wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== 16'h7003 ||
            {done, cpu_reset, error} !== 3'b110) begin
            n_err++;
            $display("FAIL reload_load: got writes=%0d done/cpu/err=%b, want (0,7003) 110",
                     wr_data_q.size(), {done, cpu_reset, error});
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] part[$] = '{8'h00, 8'h02, 8'h18};
        logic [7:0] s[$]    = '{8'h00, 8'h02, 8'h18, 8'h05, 8'h00, 8'h00, 8'h1F};
        pulse_reload();
        send(part, 0);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({rx_ready, pm_wr, pm_addr, pm_data, cpu_reset, done, error, loaded_count} !== '0) begin
            n_err++;
            $display("FAIL midreset_async: got rdy=%b cpu=%b done=%b err=%b lc=%0d, want all 0",
                     rx_ready, cpu_reset, done, error, loaded_count);
        end
        @(negedge clock);
        reset = 1'b1;
        model(s);
        send(s, 0);
        n_vec++;
        if (wr_data_q.size() !== 2 || wr_addr_q[0] !== 11'd0 || wr_data_q[0] !== exp_words[0] ||
            {done, error, cpu_reset} !== 3'b101) begin
            n_err++;
            $display("FAIL midreset_reload: got writes=%0d done/err/cpu=%b, want 2 101",
                     wr_data_q.size(), {done, error, cpu_reset});
        end
    endtask

    task automatic test_random(input int iters, input int maxc);
        for (int it = 0; it < iters; it++) begin
            logic [7:0] s[$];
            logic [7:0] x = 8'h00;
            int c = (maxc == MAXC) ? MAXC : int'($urandom_range(0, maxc));
            int bad;
            s.push_back(8'(c >> 8));
            s.push_back(8'(c));
            for (int k = 0; k < 2 * c; k++) s.push_back(8'($urandom));
            foreach (s[i]) x = x ^ s[i];
            bad = (maxc == MAXC) ? 0 : int'($urandom_range(0, 3) == 0);
            s.push_back(bad != 0 ? (x ^ 8'($urandom_range(1, 255))) : x);
            pulse_reload();
            model(s);
            send(s, (maxc == MAXC) ? 0 : int'($urandom_range(0, 2)));
            n_vec++;
            if (wr_data_q.size() !== exp_words.size()) begin
                n_err++;
                $display("FAIL rand_nwrites: got %0d, want %0d", wr_data_q.size(), exp_words.size());
            end else begin
                foreach (exp_words[i]) begin
                    n_vec++;
                    if (wr_addr_q[i] !== DW'(i) || wr_data_q[i] !== exp_words[i]) begin
                        n_err++;
                        $display("FAIL rand_write[%0d]: got (%h,%h), want (%h,%h)",
                                 i, wr_addr_q[i], wr_data_q[i], DW'(i), exp_words[i]);
                    end
                end
            end
            n_vec++;
            if ({done, error, cpu_reset} !== {exp_done, exp_err, exp_done} || loaded_count !== 12'(exp_n)) begin
                n_err++;
                $display("FAIL rand_status: got done/err/cpu=%b lc=%0d, want %b%b%b lc=%0d",
                         {done, error, cpu_reset}, loaded_count, exp_done, exp_err, exp_done, exp_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_zero_count();
        test_overflow();
        test_toggle();
        test_reload();
        test_mid_reset();
        test_random(24, 6);
        test_random(1, MAXC);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer end of the program memory that the control unit reads. Receives a byte stream over a valid/ready handshake, assembles 16-bit instructions (opcode [15:11], operand [10:0]) and writes them sequentially into program memory from address 0. Holds the CPU in reset until a checksum-verified image is loaded. Sits between the host byte source (UART RX) and the program memory write port / CPU reset.

Parameters:
DATA_WIDTH, 11, operand width; also the program memory address width (depth 2^DATA_WIDTH words)
INSTRUCTION_WIDTH, 15, MSB index of an instruction word (word is INSTRUCTION_WIDTH+1 = 16 bits)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid & rx_ready on a rising clock edge
reload  in  1  single-cycle pulse; restarts loading, honoured only in DONE or ERROR
pm_wr  out  1  program memory write strobe, one cycle per word
pm_addr  out  DATA_WIDTH  program memory write address
pm_data  out  INSTRUCTION_WIDTH+1  instruction word to write
cpu_reset  out  1  active-low reset to the CPU datapath/control; 0 until load succeeds
done  out  1  image loaded and checksum matched
error  out  1  image rejected
loaded_count  out  DATA_WIDTH+1  number of words written in current/last load

Behaviour:
- Stream format, MSB byte first: COUNT_HI, COUNT_LO, then COUNT instruction words (HI byte, LO byte each), then one CHECK byte = XOR of every preceding byte in the stream.
- Reset (async, reset=0): state CNT_HI; rx_ready=0 during reset, 1 on first cycle after release; pm_wr=0, pm_addr=0, pm_data=0, cpu_reset=0, done=0, error=0, loaded_count=0, checksum accumulator=0.
- States: CNT_HI, CNT_LO, INS_HI, INS_LO, WRITE, CHECK, DONE, ERROR.
- rx_ready=1 only in CNT_HI, CNT_LO, INS_HI, INS_LO, CHECK. State advances only on an accepted byte; rx_valid with rx_ready=0 is ignored (source holds data).
- Each accepted byte (except CHECK) is XORed into the accumulator.
- CNT_HI -> CNT_LO. CNT_LO: count = {hi, lo}. count > 2^DATA_WIDTH -> ERROR; count == 0 -> CHECK; else -> INS_HI.
- INS_HI latches the high byte -> INS_LO. INS_LO accepts the low byte -> WRITE.
- WRITE (exactly one cycle, rx_ready=0): pm_wr=1, pm_addr=loaded_count[DATA_WIDTH-1:0], pm_data={hi,lo}; loaded_count increments at the end of the cycle. If the new loaded_count == count -> CHECK, else -> INS_HI. Minimum 3 cycles per word.
- pm_addr/pm_data hold their last values outside WRITE; pm_wr=0 in every state except WRITE.
- CHECK: accepted byte == accumulator -> DONE, else -> ERROR.
- DONE: done=1, cpu_reset=1, rx_ready=0; bytes are ignored.
- ERROR: error=1, cpu_reset=0, rx_ready=0; sticky. done and error are never both 1.
- reload in DONE/ERROR: next cycle state=CNT_HI, done=0, error=0, cpu_reset=0, loaded_count=0, accumulator=0. Program memory is not cleared. reload in any other state is ignored.
- A count of exactly 2^DATA_WIDTH fills memory; the last write is to address 2^DATA_WIDTH-1 and there is no address wrap.
- Reset mid-load: immediate return to reset values. A partially written image is left in memory, and the CPU stays in reset until a full reload succeeds.

Test Plan:
- Bytes 00 02 18 05 00 00 1F, rx_valid held high -> pm_wr pulses twice: (addr 0, 0x1805), (addr 1, 0x0000); loaded_count=2; done=1, cpu_reset=1, error=0.
- Same stream with checksum 0x1E -> both writes occur; error=1, cpu_reset=0, done=0, rx_ready=0 afterward.
- Bytes 00 00 00 -> no pm_wr; done=1, loaded_count=0. Bytes 08 01 (count 2049, DATA_WIDTH=11) -> error=1 right after the second byte, no pm_wr.
- Stream from the first test with rx_valid toggling 1/0 each cycle, and rx_valid=1 during each WRITE cycle -> identical writes and done; no byte lost or duplicated.
- Reset=0 asserted mid-stream after 3 bytes -> all outputs at reset values asynchronously. A full valid stream then loads correctly from addr 0.
- From DONE, pulse reload, then send 00 01 70 03 72 -> cpu_reset drops to 0 the cycle after reload; write (addr 0, 0x7003); done=1 again.
